// File: rtl/dmem_responder_pkg.sv
// ----------------------------------------------------------------------------
// dmem_responder_pkg : shared widths and FSM encodings for the data responder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dmem_responder_pkg;

    localparam int DMEM_WORD = 32;
    localparam int STATE_W   = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dmem_responder_array.sv
// ----------------------------------------------------------------------------
// dmem_responder_array : WORD x DEPTH storage, synchronous write, async read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_responder_array #(
    parameter int WORD  = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [WORD-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [WORD-1:0] o_rdata
);

    logic [WORD-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder : valid/ready data-memory responder with LATENCY wait states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WORD    = DMEM_WORD,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [WORD-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_cnt_init = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [STATE_W-1:0] r_state;
    logic [3:0]         r_cnt;
    logic               r_write;
    logic [WORD-1:0]    r_addr;
    logic [WORD-1:0]    r_wdata;
    logic               r_resp_valid;
    logic               r_resp_err;
    logic [WORD-1:0]    r_resp_rdata;

    logic               w_accept;
    logic               w_enter_resp;
    logic               w_acc_write;
    logic [WORD-1:0]    w_acc_addr;
    logic [WORD-1:0]    w_acc_wdata;
    logic               w_acc_err;
    logic [AW-1:0]      w_idx;
    logic               w_we;
    logic [WORD-1:0]    w_rd;

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid && req_ready;

    // With zero latency the access happens on the accept edge, before the latches hold the request.
    assign w_acc_write = req_ready ? req_write : r_write;
    assign w_acc_addr  = req_ready ? req_addr  : r_addr;
    assign w_acc_wdata = req_ready ? req_wdata : r_wdata;

    assign w_acc_err    = (w_acc_addr[1:0] != 2'b00) || ((w_acc_addr >> 2) >= WORD'(DEPTH));
    assign w_idx        = w_acc_addr[AW+1:2];
    assign w_enter_resp = (w_accept && (LATENCY == 0)) ||
                          ((r_state == ST_WAIT) && (r_cnt == 4'd0));
    assign w_we         = w_enter_resp && w_acc_write && !w_acc_err;

    dmem_responder_array #(
        .WORD  (WORD),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (w_acc_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        if (LATENCY == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_cnt_init;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (r_resp_valid && resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Response payload is captured once, on entry to RESP, and held until consumed.
            if (w_enter_resp) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_acc_err;
                r_resp_rdata <= (w_acc_write || w_acc_err) ? '0 : w_rd;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

`default_nettype wire
